spindle_slot_scheduler: RTL and testbench
=========================================

// Module: spindle_slot_scheduler
// PURPOSE
//   Sequences the shared, time-multiplexed spindle fiber datapath (derivatives + Euler integrators)
//   across N_MUSCLE spindles x 3 fibers (bag1, bag2, chain) once per integration step.
//   Issues one (muscle, fiber) slot per clock and raises a write-back strobe DP_LAT cycles later.
//   Signals round completion to the step/muscle layer and flags step overruns.
// PARAMETERS
//   N_MUSCLE  4  number of spindle instances sharing the datapath (>=1)
//   DP_LAT    2  clocks from slot issue to datapath result valid (>=1)
//   MW        max(1,$clog2(N_MUSCLE))  muscle index width (derived, localparam)
// PORTS
//   clk            in   1   clock
//   reset          in   1   asynchronous, active-high reset
//   enable         in   1   1 = accept step pulses
//   step           in   1   one-cycle pulse: start a new integration round
//   clear_overrun  in   1   clears sticky overrun flag
//   issue          out  1   slot valid to datapath this cycle
//   muscle_id      out  MW  muscle index of issued slot
//   fiber_sel      out  2   fiber of issued slot: 0 bag1, 1 bag2, 2 chain (3 never driven)
//   wb_en          out  1   write-back strobe: datapath result for wb_muscle/wb_fiber is valid
//   wb_muscle      out  MW  muscle index being written back
//   wb_fiber       out  2   fiber being written back
//   busy           out  1   round in progress (ISSUE or DRAIN)
//   round_done     out  1   one-cycle pulse after last write-back of a round
//   overrun        out  1   sticky: step arrived while busy
//   step_count     out  16  completed rounds, wraps 0xFFFF->0
// BEHAVIOUR
//   - Reset (async): FSM->IDLE, slot counters 0, write-back pipe flushed; all outputs 0,
//     step_count 0, overrun 0. Reset mid-round abandons the round; no wb_en/round_done follow.
//   - FSM states: IDLE, ISSUE, DRAIN, DONE.
//     IDLE : step & enable -> ISSUE (next cycle is first issue). step & !enable ignored.
//     ISSUE: issue=1 every cycle, order m0f0,m0f1,m0f2,m1f0,...,m(N-1)f2 (fiber inner loop);
//            after slot (N_MUSCLE-1, 2) -> DRAIN. 3*N_MUSCLE issue cycles, no gaps.
//     DRAIN: issue=0; wait until write-back pipe empty -> DONE.
//     DONE : round_done=1 for one cycle, step_count+=1 -> IDLE.
//   - busy=1 in ISSUE and DRAIN only; issue/muscle_id/fiber_sel are 0 when not in ISSUE.
//   - Write-back pipe: DP_LAT-deep shift register of {valid,muscle,fiber}; wb_* equal the
//     issue-side values exactly DP_LAT cycles later; wb_* fields 0 when wb_en=0.
//   - Timing (step sampled high at cycle t): issues t+1..t+3N, wb_en t+1+DP_LAT..t+3N+DP_LAT,
//     round_done at t+3N+DP_LAT+1; earliest next accepted step is cycle t+3N+DP_LAT+2 (IDLE).
//   - step while busy or in DONE: ignored for sequencing, overrun<=1. step and
//     clear_overrun in same cycle while not IDLE: set wins. clear_overrun otherwise clears.
//   - enable deasserted mid-round does not abort; round completes normally.
//   - N_MUSCLE=1: muscle_id/wb_muscle constant 0, 3 slots per round.
// TESTING
//   1. N=4,DP_LAT=2, reset then step at cycle 10 -> issue 11..22 order m0f0..m3f2, wb_en 13..24
//      matching, round_done only at 25, step_count=1, busy 11..24.
//   2. Second step at cycle 15 during round -> sequence unchanged, overrun=1 from cycle 16;
//      clear_overrun at 30 -> overrun=0 at 31.
//   3. enable=0, step pulse -> no issue, busy stays 0; enable drops at cycle 14 mid-round ->
//      round still completes at cycle 25.
//   4. reset asserted at cycle 17 mid-round -> all outputs 0 immediately, no wb_en/round_done
//      afterward; step at 30 starts clean round from m0f0 at 31.
//   5. Preload-free wrap: run 65536 rounds (step pulse after each round_done) -> step_count 0.
//   6. N=1,DP_LAT=1: step at 5 -> issue 6..8 (fibers 0,1,2), wb_en 7..9, round_done at 10.

Source files
------------

// File: rtl/spindle_slot_scheduler_if.sv
// Control and slot/write-back bus between the step layer and the spindle slot scheduler.
interface spindle_slot_scheduler_if #(
    parameter int unsigned MW = 2
);
    logic          enable;
    logic          step;
    logic          clear_overrun;
    logic          issue;
    logic [MW-1:0] muscle_id;
    logic [1:0]    fiber_sel;
    logic          wb_en;
    logic [MW-1:0] wb_muscle;
    logic [1:0]    wb_fiber;
    logic          busy;
    logic          round_done;
    logic          overrun;
    logic [15:0]   step_count;

    modport master (
        output enable, step, clear_overrun,
        input  issue, muscle_id, fiber_sel, wb_en, wb_muscle, wb_fiber,
               busy, round_done, overrun, step_count
    );

    modport slave (
        input  enable, step, clear_overrun,
        output issue, muscle_id, fiber_sel, wb_en, wb_muscle, wb_fiber,
               busy, round_done, overrun, step_count
    );
endinterface

// File: rtl/spindle_slot_scheduler.sv
// Sequences the shared spindle fiber datapath across N_MUSCLE x 3 fiber slots per integration step,
// tracks results through a DP_LAT-deep write-back pipe, and reports round completion and overruns.
module spindle_slot_scheduler #(
    parameter int unsigned N_MUSCLE = 4,
    parameter int unsigned DP_LAT   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    spindle_slot_scheduler_if.slave  bus
);
    localparam int unsigned MW = (N_MUSCLE > 1) ? $clog2(N_MUSCLE) : 1;
    localparam int unsigned FW = 2;
    localparam int unsigned CW = 16;

    localparam logic [MW-1:0] LAST_MUSCLE = MW'(N_MUSCLE - 1);
    localparam logic [FW-1:0] LAST_FIBER  = FW'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic          valid;
        logic [MW-1:0] muscle;
        logic [FW-1:0] fiber;
    } slot_t;

    state_t        state, state_n;
    logic [MW-1:0] slot_muscle, slot_muscle_n;
    logic [FW-1:0] slot_fiber, slot_fiber_n;
    logic          issue_q, issue_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          overrun_q, overrun_n;
    logic [CW-1:0] count_q, count_n;
    slot_t         pipe [DP_LAT];
    logic          pipe_pending_c;

    // Slots still in flight that will not have reached write-back after this edge.
    always_comb begin
        pipe_pending_c = 1'b0;
        for (int unsigned i = 0; i + 1 < DP_LAT; i++) begin
            pipe_pending_c = pipe_pending_c | pipe[i].valid;
        end
    end

    // Next-state and next registered outputs; slot fields stay zero outside ISSUE.
    always_comb begin
        state_n       = state;
        slot_muscle_n = '0;
        slot_fiber_n  = '0;
        issue_n       = 1'b0;
        busy_n        = 1'b0;
        done_n        = 1'b0;
        count_n       = count_q;
        overrun_n     = overrun_q;

        case (state)
            IDLE: begin
                if (bus.step && bus.enable) begin
                    state_n = ISSUE;
                    issue_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            ISSUE: begin
                busy_n = 1'b1;
                if (slot_muscle == LAST_MUSCLE && slot_fiber == LAST_FIBER) begin
                    state_n = DRAIN;
                end else begin
                    issue_n = 1'b1;
                    if (slot_fiber == LAST_FIBER) begin
                        slot_muscle_n = slot_muscle + MW'(1);
                        slot_fiber_n  = '0;
                    end else begin
                        slot_muscle_n = slot_muscle;
                        slot_fiber_n  = slot_fiber + FW'(1);
                    end
                end
            end
            DRAIN: begin
                if (pipe_pending_c) begin
                    busy_n = 1'b1;
                end else begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    count_n = count_q + CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A step outside IDLE marks an overrun; setting beats a simultaneous clear.
        if (bus.step && state != IDLE) begin
            overrun_n = 1'b1;
        end else if (bus.clear_overrun) begin
            overrun_n = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            slot_muscle <= '0;
            slot_fiber  <= '0;
            issue_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state       <= state_n;
            slot_muscle <= slot_muscle_n;
            slot_fiber  <= slot_fiber_n;
            issue_q     <= issue_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            overrun_q   <= overrun_n;
            count_q     <= count_n;
        end
    end

    // Write-back pipe: issued slot reappears at the tail exactly DP_LAT cycles later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DP_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: issue_q, muscle: slot_muscle, fiber: slot_fiber};
            for (int unsigned i = 1; i < DP_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign bus.issue      = issue_q;
    assign bus.muscle_id  = slot_muscle;
    assign bus.fiber_sel  = slot_fiber;
    assign bus.wb_en      = pipe[DP_LAT-1].valid;
    assign bus.wb_muscle  = pipe[DP_LAT-1].muscle;
    assign bus.wb_fiber   = pipe[DP_LAT-1].fiber;
    assign bus.busy       = busy_q;
    assign bus.round_done = done_q;
    assign bus.overrun    = overrun_q;
    assign bus.step_count = count_q;
endmodule

// File: tb/tb_spindle_slot_scheduler.sv
// Bench for spindle_slot_scheduler: two configurations driven by directed and random steps,
// compared every cycle against a round-timing model built from step acceptance times.
module tb_spindle_slot_scheduler;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    spindle_slot_scheduler_if #(.MW(2)) bus_a ();
    spindle_slot_scheduler_if #(.MW(1)) bus_b ();

    spindle_slot_scheduler #(.N_MUSCLE(4), .DP_LAT(2)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    spindle_slot_scheduler #(.N_MUSCLE(1), .DP_LAT(1)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    int compared   = 0;
    int mismatched = 0;

    // Active configuration and model state
    int sel   = 0;
    int n_m   = 4;
    int lat   = 2;
    int cur   = 0;
    bit active = 1'b0;
    int t0    = 0;
    bit ov_exp = 1'b0;
    int cnt_exp = 0;
    bit st = 1'b0, en = 1'b0, clr = 1'b0;

    logic [31:0] o_issue, o_m, o_f, o_wb, o_wm, o_wf, o_busy, o_done, o_ov, o_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        compared++;
        assert (obs === 32'(exp)) else begin
            mismatched++;
            $error("FAIL %s cfg%0d cycle %0d: observed %0d expected %0d", tag, sel, cur, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input bit e, input bit c);
        st = s; en = e; clr = c;
        if (sel == 0) begin
            bus_a.step = s; bus_a.enable = e; bus_a.clear_overrun = c;
        end else begin
            bus_b.step = s; bus_b.enable = e; bus_b.clear_overrun = c;
        end
    endtask

    task automatic sample();
        if (sel == 0) begin
            o_issue = 32'(bus_a.issue);   o_m  = 32'(bus_a.muscle_id); o_f  = 32'(bus_a.fiber_sel);
            o_wb    = 32'(bus_a.wb_en);   o_wm = 32'(bus_a.wb_muscle); o_wf = 32'(bus_a.wb_fiber);
            o_busy  = 32'(bus_a.busy);    o_done = 32'(bus_a.round_done);
            o_ov    = 32'(bus_a.overrun); o_cnt  = 32'(bus_a.step_count);
        end else begin
            o_issue = 32'(bus_b.issue);   o_m  = 32'(bus_b.muscle_id); o_f  = 32'(bus_b.fiber_sel);
            o_wb    = 32'(bus_b.wb_en);   o_wm = 32'(bus_b.wb_muscle); o_wf = 32'(bus_b.wb_fiber);
            o_busy  = 32'(bus_b.busy);    o_done = 32'(bus_b.round_done);
            o_ov    = 32'(bus_b.overrun); o_cnt  = 32'(bus_b.step_count);
        end
    endtask

    // Position of cycle c inside the current round (-1 = cycle the step was accepted)
    function automatic int rel(input int c);
        return c - t0 - 1;
    endfunction

    function automatic bit is_idle(input int c);
        return !active || rel(c) >= 3*n_m + lat + 1;
    endfunction

    // Expected outputs for cycle cur, derived from the accepted step time
    task automatic check_all();
        int k, kw;
        bit e_issue, e_wb, e_busy, e_done;
        k  = rel(cur);
        kw = k - lat;
        e_issue = active && k >= 0 && k < 3*n_m;
        e_wb    = active && kw >= 0 && kw < 3*n_m;
        e_busy  = active && k >= 0 && k < 3*n_m + lat;
        e_done  = active && k == 3*n_m + lat;
        sample();
        check("issue",      o_issue, int'(e_issue));
        check("muscle_id",  o_m,     e_issue ? k / 3 : 0);
        check("fiber_sel",  o_f,     e_issue ? k % 3 : 0);
        check("wb_en",      o_wb,    int'(e_wb));
        check("wb_muscle",  o_wm,    e_wb ? kw / 3 : 0);
        check("wb_fiber",   o_wf,    e_wb ? kw % 3 : 0);
        check("busy",       o_busy,  int'(e_busy));
        check("round_done", o_done,  int'(e_done));
        check("overrun",    o_ov,    int'(ov_exp));
        check("step_count", o_cnt,   cnt_exp);
    endtask

    // Apply current inputs to the model, advance one clock, compare outputs
    task automatic tick();
        bit idle, ov_next;
        idle    = is_idle(cur);
        ov_next = ov_exp;
        if (st && !idle) ov_next = 1'b1;
        else if (clr)    ov_next = 1'b0;
        if (st && idle && en) begin
            active = 1'b1;
            t0     = cur;
        end
        @(posedge clk);
        cur++;
        ov_exp = ov_next;
        if (active && rel(cur) == 3*n_m + lat) cnt_exp = (cnt_exp + 1) % 65536;
        #1;
        check_all();
    endtask

    task automatic run_to(input int c);
        while (cur < c) tick();
    endtask

    task automatic pulse(input bit s, input bit c);
        drive(s, en, c);
        tick();
        drive(1'b0, en, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle: outputs must clear before any clock edge
    task automatic reset_dut();
        drive(1'b0, en, 1'b0);
        #2;
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
        active = 1'b0; ov_exp = 1'b0; cnt_exp = 0;
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
        cur = 0;
    endtask

    initial begin
        bus_a.step = 1'b0; bus_a.enable = 1'b0; bus_a.clear_overrun = 1'b0;
        bus_b.step = 1'b0; bus_b.enable = 1'b0; bus_b.clear_overrun = 1'b0;

        // Configuration A: N_MUSCLE=4, DP_LAT=2
        sel = 0; n_m = 4; lat = 2;
        @(posedge clk);
        #1;
        reset_dut();
        drive(1'b0, 1'b1, 1'b0);

        // Basic round plus overrun during the round, later cleared
        run_to(10);
        pulse(1'b1, 1'b0);
        run_to(15);
        pulse(1'b1, 1'b0);
        run_to(30);
        pulse(1'b0, 1'b1);
        run_to(40);

        // Overrun set and clear together while busy: set wins
        pulse(1'b1, 1'b0);
        repeat (3) tick();
        pulse(1'b1, 1'b1);
        run_to(70);
        pulse(1'b0, 1'b1);

        // Step ignored while disabled
        drive(1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        repeat (4) tick();

        // Enable dropped mid-round: round still completes
        drive(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        repeat (3) tick();
        drive(1'b0, 1'b0, 1'b0);
        repeat (20) tick();
        drive(1'b0, 1'b1, 1'b0);

        // Reset mid-round abandons it; next step starts cleanly
        pulse(1'b1, 1'b0);
        repeat (6) tick();
        reset_dut();
        drive(1'b0, 1'b1, 1'b0);
        run_to(30);
        pulse(1'b1, 1'b0);
        run_to(50);

        // Random steps, enables and clears
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 4) == 0, ($urandom % 8) != 0, ($urandom % 16) == 0);
            tick();
        end

        // Configuration B: N_MUSCLE=1, DP_LAT=1
        drive(1'b0, 1'b0, 1'b0);
        sel = 1; n_m = 1; lat = 1;
        reset_dut();
        drive(1'b0, 1'b1, 1'b0);
        run_to(5);
        pulse(1'b1, 1'b0);
        run_to(15);
        for (int i = 0; i < 1000; i++) begin
            drive(($urandom % 3) == 0, ($urandom % 8) != 0, ($urandom % 16) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
